// File: rtl/cpu_pkg.sv
// Shared definitions for the write-back stage: well-known register
// numbers for the syscall taps, the syscall codes and the FSM states.
package cpu_pkg;

    localparam logic [3:0]  REG_V0   = 4'd2;
    localparam logic [3:0]  REG_A0   = 4'd4;
    localparam logic [31:0] SYS_EXIT = 32'd10;
    localparam logic [31:0] SYS_SHOW = 32'd34;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_array.sv
// Register file storage: one write port, two combinational read ports with
// same-cycle write-through, and two fixed taps ($v0, $a0) that always show
// the committed (pre-write) contents. Register 0 always reads as zero.
module regfile_array
    import cpu_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_wa,
    input  logic [DW-1:0] i_wd,
    input  logic [AW-1:0] i_ra1,
    input  logic [AW-1:0] i_ra2,
    output logic [DW-1:0] o_rd1,
    output logic [DW-1:0] o_rd2,
    output logic [DW-1:0] o_v0,
    output logic [DW-1:0] o_a0
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0] r_regs [NREG];

    logic w_bypass1;
    logic w_bypass2;

    // Commit the write-back value; writes aimed at register 0 are dropped
    // so that location stays zero for the whole run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wa != '0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    // Read ports see a write landing this cycle so the ID stage never has to
    // wait for the commit; register 0 wins over everything.
    always_comb begin
        w_bypass1 = i_we && (i_wa == i_ra1);
        w_bypass2 = i_we && (i_wa == i_ra2);
        o_rd1 = (i_ra1 == '0) ? '0 : (w_bypass1 ? i_wd : r_regs[i_ra1]);
        o_rd2 = (i_ra2 == '0) ? '0 : (w_bypass2 ? i_wd : r_regs[i_ra2]);
    end

    // Syscall taps look straight at the array, never at the bypass path,
    // so a write retiring alongside a syscall does not affect its arguments.
    always_comb begin
        o_v0 = r_regs[int'(REG_V0)];
        o_a0 = r_regs[int'(REG_A0)];
    end

endmodule

// File: rtl/wb_regfile_syscall.sv
// Write-back endpoint: commits results to the register file, services
// retiring syscalls (exit / show), keeps the display latch and the run-cycle
// counter, and produces the global pipeline-advance signal.
module wb_regfile_syscall
    import cpu_pkg::*;
#(
    parameter int          DW        = 32,
    parameter int          AW        = 4,
    parameter int unsigned EXIT_CODE = 10,
    parameter int unsigned SHOW_CODE = 34
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_rw,
    input  logic [DW-1:0] wb_data,
    input  logic          wb_syscall,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          resume,
    output logic          go,
    output logic          halted,
    output logic [DW-1:0] disp,
    output logic          disp_valid,
    output logic [31:0]   run_cycles
);

    state_t r_state;
    state_t w_nextState;

    logic [DW-1:0] r_disp;
    logic          r_dispValid;
    logic [31:0]   r_runCycles;

    logic          w_go;
    logic          w_writeEn;
    logic          w_showHit;
    logic [DW-1:0] w_v0;
    logic [DW-1:0] w_a0;

    // go and halted come straight from the state flop, so they are
    // registered, mutually exclusive and only move on the edge after a cause.
    assign w_go       = (r_state == ST_RUN);
    assign w_writeEn  = wb_we && w_go;
    assign go         = w_go;
    assign halted     = (r_state == ST_HALT);
    assign disp       = r_disp;
    assign disp_valid = r_dispValid;
    assign run_cycles = r_runCycles;

    regfile_array #(
        .DW(DW),
        .AW(AW)
    ) u_regs (
        .clk   (clk),
        .rst_n (rst_n),
        .i_we  (w_writeEn),
        .i_wa  (wb_rw),
        .i_wd  (wb_data),
        .i_ra1 (ra1),
        .i_ra2 (ra2),
        .o_rd1 (rd1),
        .o_rd2 (rd2),
        .o_v0  (w_v0),
        .o_a0  (w_a0)
    );

    // State register for the run/halt machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Syscall decode: exit halts, show requests a display update, anything
    // else is ignored. In HALT only resume matters.
    always_comb begin
        w_nextState = r_state;
        w_showHit   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (wb_syscall) begin
                    if (w_v0 == DW'(EXIT_CODE)) begin
                        w_nextState = ST_HALT;
                    end else if (w_v0 == DW'(SHOW_CODE)) begin
                        w_showHit = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                if (resume) begin
                    w_nextState = ST_RUN;
                end
            end
            default: begin
                w_nextState = ST_RUN;
            end
        endcase
    end

    // Display latch holds $a0 from the most recent show syscall; the valid
    // flag is a one-cycle registered pulse alongside the update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp      <= '0;
            r_dispValid <= 1'b0;
        end else begin
            r_dispValid <= w_showHit;
            if (w_showHit) begin
                r_disp <= w_a0;
            end
        end
    end

    // Count cycles spent running; frozen while halted, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_runCycles <= '0;
        end else if (r_state == ST_RUN) begin
            r_runCycles <= r_runCycles + 32'd1;
        end
    end

endmodule
